// File: rtl/jtag_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jtag_seq_pkg : shared types and constants for the JTAG command sequencer   |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
package jtag_seq_pkg;

   localparam int MAX_BITS_DEF  = 16;
   localparam int IDX_W         = 4;
   localparam int TAP_RESET_LEN = 5;

   typedef enum logic [1:0] {
      OP_TMS_SEQ    = 2'd0,
      OP_SHIFT      = 2'd1,
      OP_SHIFT_EXIT = 2'd2,
      OP_TAP_RESET  = 2'd3
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2,
      ST_RSP  = 2'd3
   } state_t;

   typedef struct packed {
      logic tms;
      logic tdi;
   } pins_t;

   // Pin levels for one bit of a command.
   function automatic pins_t bit_pins(input op_t op, input logic data_bit, input logic is_last);
      pins_t p;
      p.tms = 1'b0;
      p.tdi = 1'b0;
      case (op)
         OP_TMS_SEQ:    p.tms = data_bit;
         OP_SHIFT:      p.tdi = data_bit;
         OP_SHIFT_EXIT: begin
            p.tdi = data_bit;
            p.tms = is_last;
         end
         default:       p.tms = 1'b1;
      endcase
      return p;
   endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_tck_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jtag_tck_divider : TCK half-period counter, reloaded at each phase start   |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module jtag_tck_divider #(
   parameter int TICK_DELAY = 10,
   parameter int CW         = $clog2(TICK_DELAY + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic [CW-1:0] count,
   output logic          phase_done
);

   localparam logic [CW-1:0] RELOAD = CW'(TICK_DELAY);

   // count runs TICK_DELAY..1 across a phase, then parks at 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (start) begin
         count <= RELOAD;
      end else if (count != '0) begin
         count <= count - CW'(1);
      end
   end

   assign phase_done = (count == CW'(1));

endmodule
`default_nettype wire

// File: rtl/jtag_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jtag_cmd_sequencer : valid/ready command stream to TCK/TMS/TDI, TDO capture|
// | Option: JTAG_SEQ_TDO_SYNC_EN adds a two-flop TDO synchronizer.             |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
module jtag_cmd_sequencer
   import jtag_seq_pkg::*;
#(
   parameter int TICK_DELAY = 10,
   parameter int MAX_BITS   = MAX_BITS_DEF
) (
   input  logic                io_clk,
   input  logic                io_reset,
   input  logic                io_cmd_valid,
   output logic                io_cmd_ready,
   input  logic [1:0]          io_cmd_op,
   input  logic [3:0]          io_cmd_len,
   input  logic [MAX_BITS-1:0] io_cmd_data,
   output logic                io_rsp_valid,
   input  logic                io_rsp_ready,
   output logic [MAX_BITS-1:0] io_rsp_data,
   output logic                io_jtag_tck,
   output logic                io_jtag_tms,
   output logic                io_jtag_tdi,
   input  logic                io_jtag_tdo,
   output logic                io_busy
);

   localparam int CW = $clog2(TICK_DELAY + 1);

   state_t              state;
   state_t              next_state;
   op_t                 op;
   logic [MAX_BITS-1:0] data;
   logic [MAX_BITS-1:0] rsp_data;
   logic [IDX_W-1:0]    idx;
   logic [IDX_W-1:0]    last_idx;
   logic [IDX_W-1:0]    idx_nxt;
   logic [IDX_W-1:0]    last_in;
   logic [CW-1:0]       count;
   logic                phase_done;
   logic                accept;
   logic                advance;
   logic                div_start;
   logic                capture_en;
   logic                tdo_s;
   logic                tck;
   logic                tms;
   logic                tdi;
   pins_t               pins_acc;
   pins_t               pins_nxt;

   jtag_tck_divider #(
      .TICK_DELAY (TICK_DELAY),
      .CW         (CW)
   ) u_div (
      .clk        (io_clk),
      .rst        (io_reset),
      .start      (div_start),
      .count      (count),
      .phase_done (phase_done)
   );

`ifdef JTAG_SEQ_TDO_SYNC_EN
   logic [1:0] tdo_sync;

   always_ff @(posedge io_clk or posedge io_reset) begin
      if (io_reset) begin
         tdo_sync <= '0;
      end else begin
         tdo_sync <= {tdo_sync[0], io_jtag_tdo};
      end
   end

   // Two cycles after TCK rises the synchronized TDO reflects the level at the rise.
   assign tdo_s      = tdo_sync[1];
   assign capture_en = (state == ST_HIGH) && (count == CW'(TICK_DELAY - 1));
`else
   // Capture on the edge that registers TCK high, i.e. the last LOW cycle.
   assign tdo_s      = io_jtag_tdo;
   assign capture_en = (state == ST_LOW) && (count == CW'(1));
`endif

   assign last_in  = (op_t'(io_cmd_op) == OP_TAP_RESET) ? IDX_W'(TAP_RESET_LEN - 1) : io_cmd_len;
   assign idx_nxt  = idx + IDX_W'(1);
   assign pins_acc = bit_pins(op_t'(io_cmd_op), io_cmd_data[0], last_in == '0);
   assign pins_nxt = bit_pins(op, data[idx_nxt], idx_nxt == last_idx);

   always_ff @(posedge io_clk or posedge io_reset) begin
      if (io_reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state   = state;
      accept       = 1'b0;
      advance      = 1'b0;
      div_start    = 1'b0;
      io_cmd_ready = 1'b0;
      io_rsp_valid = 1'b0;
      io_busy      = 1'b1;
      case (state)
         ST_IDLE: begin
            io_cmd_ready = 1'b1;
            io_busy      = 1'b0;
            if (io_cmd_valid) begin
               accept     = 1'b1;
               div_start  = 1'b1;
               next_state = ST_LOW;
            end
         end
         ST_LOW: begin
            if (phase_done) begin
               div_start  = 1'b1;
               next_state = ST_HIGH;
            end
         end
         ST_HIGH: begin
            if (phase_done) begin
               if (idx == last_idx) begin
                  next_state = ST_RSP;
               end else begin
                  advance    = 1'b1;
                  div_start  = 1'b1;
                  next_state = ST_LOW;
               end
            end
         end
         ST_RSP: begin
            io_rsp_valid = 1'b1;
            if (io_rsp_ready) begin
               next_state = ST_IDLE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // TMS/TDI change only when a bit starts, so the pins hold their last level while idle.
   always_ff @(posedge io_clk or posedge io_reset) begin
      if (io_reset) begin
         op       <= OP_TMS_SEQ;
         data     <= '0;
         idx      <= '0;
         last_idx <= '0;
         rsp_data <= '0;
         tck      <= 1'b0;
         tms      <= 1'b1;
         tdi      <= 1'b0;
      end else begin
         tck <= (next_state == ST_HIGH);
         if (accept) begin
            op       <= op_t'(io_cmd_op);
            data     <= io_cmd_data;
            idx      <= '0;
            last_idx <= last_in;
            rsp_data <= '0;
            tms      <= pins_acc.tms;
            tdi      <= pins_acc.tdi;
         end else if (advance) begin
            idx <= idx_nxt;
            tms <= pins_nxt.tms;
            tdi <= pins_nxt.tdi;
         end
         if (capture_en && (op != OP_TAP_RESET)) begin
            rsp_data[idx] <= tdo_s;
         end
      end
   end

   assign io_rsp_data = rsp_data;
   assign io_jtag_tck = tck;
   assign io_jtag_tms = tms;
   assign io_jtag_tdi = tdi;

endmodule
`default_nettype wire

// File: tb/tb_jtag_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_jtag_cmd_sequencer : self-checking bench with a behavioural JTAG target |
// | Revision              : 1.0                                                |
// +----------------------------------------------------------------------------+
module tb_jtag_cmd_sequencer;

   localparam int D  = 2;
   localparam int MB = 16;

   logic          io_clk       = 1'b0;
   logic          io_reset     = 1'b1;
   logic          io_cmd_valid = 1'b0;
   logic          io_cmd_ready;
   logic [1:0]    io_cmd_op    = 2'd0;
   logic [3:0]    io_cmd_len   = 4'd0;
   logic [MB-1:0] io_cmd_data  = '0;
   logic          io_rsp_valid;
   logic          io_rsp_ready = 1'b0;
   logic [MB-1:0] io_rsp_data;
   logic          io_jtag_tck;
   logic          io_jtag_tms;
   logic          io_jtag_tdi;
   logic          io_jtag_tdo  = 1'b0;
   logic          io_busy;

   jtag_cmd_sequencer #(.TICK_DELAY(D), .MAX_BITS(MB)) dut (
      .io_clk       (io_clk),
      .io_reset     (io_reset),
      .io_cmd_valid (io_cmd_valid),
      .io_cmd_ready (io_cmd_ready),
      .io_cmd_op    (io_cmd_op),
      .io_cmd_len   (io_cmd_len),
      .io_cmd_data  (io_cmd_data),
      .io_rsp_valid (io_rsp_valid),
      .io_rsp_ready (io_rsp_ready),
      .io_rsp_data  (io_rsp_data),
      .io_jtag_tck  (io_jtag_tck),
      .io_jtag_tms  (io_jtag_tms),
      .io_jtag_tdi  (io_jtag_tdi),
      .io_jtag_tdo  (io_jtag_tdo),
      .io_busy      (io_busy)
   );

   always #5 io_clk = ~io_clk;

   int cyc = 0;
   initial forever begin
      @(posedge io_clk);
      cyc++;
   end

   // Target: TDO either loops TDI back half an io_clk later or plays tdo_pat[bit].
   logic          lb_mode = 1'b0;
   logic [15:0]   tdo_pat = '0;
   int            rises   = 0;
   logic          tck_q   = 1'b0;
   logic          busy_q  = 1'b0;
   logic          tms_rec[$];
   logic          tdi_rec[$];

   initial forever begin
      @(negedge io_clk);
      if (io_busy && !busy_q) begin
         rises = 0;
         tms_rec.delete();
         tdi_rec.delete();
      end
      if (io_jtag_tck && !tck_q) begin
         rises = rises + 1;
         tms_rec.push_back(io_jtag_tms);
         tdi_rec.push_back(io_jtag_tdi);
      end
      tck_q  = io_jtag_tck;
      busy_q = io_busy;
      if (lb_mode) io_jtag_tdo = io_jtag_tdi;
      else         io_jtag_tdo = (rises < 16) ? tdo_pat[rises] : 1'b0;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] pack_q(input logic q[$]);
      logic [15:0] v;
      v = '0;
      for (int i = 0; i < q.size() && i < 16; i++) v[i] = q[i];
      return v;
   endfunction

   // Reference model built straight from the per-op bit rules.
   function automatic void model(input logic [1:0] op, input logic [3:0] len, input logic [15:0] data,
                                 input logic lb, input logic [15:0] pat, output int n,
                                 output logic [15:0] tms, output logic [15:0] tdi, output logic [15:0] rsp);
      n   = (op == 2'd3) ? 5 : int'(len) + 1;
      tms = '0;
      tdi = '0;
      rsp = '0;
      for (int i = 0; i < n; i++) begin
         case (op)
            2'd0: tms[i] = data[i];
            2'd1: tdi[i] = data[i];
            2'd2: begin tdi[i] = data[i]; tms[i] = (i == n - 1); end
            default: tms[i] = 1'b1;
         endcase
         if (op != 2'd3) rsp[i] = lb ? tdi[i] : pat[i];
      end
   endfunction

   int          exp_n;
   logic [15:0] exp_tms, exp_tdi, exp_rsp;
   int          t_acc;

   task automatic start_cmd(input logic [1:0] op, input logic [3:0] len, input logic [15:0] data, input string name);
      bit ok;
      ok = 1'b0;
      io_cmd_op    = op;
      io_cmd_len   = len;
      io_cmd_data  = data;
      io_cmd_valid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         if (io_cmd_ready) begin
            ok    = 1'b1;
            t_acc = cyc;
            break;
         end
         @(negedge io_clk);
      end
      check({name, " accept"}, 32'(ok), 32'd1);
      @(negedge io_clk);
      io_cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string name);
      bit ok;
      int t_rsp;
      ok    = 1'b0;
      t_rsp = 0;
      for (int k = 0; k < 2 * 16 * D + 20; k++) begin
         if (io_rsp_valid) begin
            ok    = 1'b1;
            t_rsp = cyc;
            break;
         end
         @(negedge io_clk);
      end
      check({name, " rsp seen"}, 32'(ok), 32'd1);
      check({name, " latency"}, 32'(t_rsp - t_acc), 32'(1 + 2 * exp_n * D));
      check({name, " tck pulses"}, 32'(rises), 32'(exp_n));
      check({name, " tms bits"}, 32'(pack_q(tms_rec)), 32'(exp_tms));
      check({name, " tdi bits"}, 32'(pack_q(tdi_rec)), 32'(exp_tdi));
      check({name, " rsp data"}, 32'(io_rsp_data), 32'(exp_rsp));
   endtask

   task automatic ack_rsp(input string name, input int delay);
      for (int k = 0; k < delay; k++) @(negedge io_clk);
      check({name, " rsp held"}, {15'd0, io_rsp_valid, io_rsp_data}, {15'd0, 1'b1, exp_rsp});
      io_rsp_ready = 1'b1;
      @(negedge io_clk);
      io_rsp_ready = 1'b0;
      check({name, " back idle"}, {29'd0, io_rsp_valid, io_cmd_ready, io_busy}, {29'd0, 3'b010});
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [3:0]  len;
      logic [15:0] data;
      logic        lb;
      logic [15:0] pat;
      int          n;
      logic [15:0] tms;
      logic [15:0] tdi;
      logic [15:0] rsp;
   } vec_t;

   vec_t vt[11];

   initial begin
      //            op    len    data      lb    pat       n   tms       tdi       rsp
      vt[0]  = '{2'd3, 4'd0,  16'h0000, 1'b0, 16'hFFFF, 5,  16'h001F, 16'h0000, 16'h0000};
      vt[1]  = '{2'd1, 4'd7,  16'h00A5, 1'b1, 16'h0000, 8,  16'h0000, 16'h00A5, 16'h00A5};
      vt[2]  = '{2'd2, 4'd3,  16'h0003, 1'b0, 16'h0005, 4,  16'h0008, 16'h0003, 16'h0005};
      vt[3]  = '{2'd0, 4'd4,  16'h0006, 1'b0, 16'h001F, 5,  16'h0006, 16'h0000, 16'h001F};
      vt[4]  = '{2'd1, 4'd15, 16'hBEEF, 1'b1, 16'h0000, 16, 16'h0000, 16'hBEEF, 16'hBEEF};
      vt[5]  = '{2'd2, 4'd0,  16'h0001, 1'b0, 16'h0000, 1,  16'h0001, 16'h0001, 16'h0000};
      vt[6]  = '{2'd0, 4'd0,  16'h0000, 1'b0, 16'h0001, 1,  16'h0000, 16'h0000, 16'h0001};
      vt[7]  = '{2'd3, 4'd9,  16'hFFFF, 1'b0, 16'hFFFF, 5,  16'h001F, 16'h0000, 16'h0000};
      vt[8]  = '{2'd2, 4'd15, 16'h8001, 1'b0, 16'hFFFF, 16, 16'h8000, 16'h8001, 16'hFFFF};
      vt[9]  = '{2'd1, 4'd3,  16'h000C, 1'b0, 16'hFFF6, 4,  16'h0000, 16'h000C, 16'h0006};
      vt[10] = '{2'd0, 4'd15, 16'h1234, 1'b1, 16'h0000, 16, 16'h1234, 16'h0000, 16'h0000};

      repeat (3) @(negedge io_clk);
      io_reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge io_clk);
         check("reset idle pins", {26'd0, io_jtag_tck, io_jtag_tms, io_jtag_tdi, io_rsp_valid, io_cmd_ready, io_busy},
               {26'd0, 6'b010010});
         check("reset rsp data", 32'(io_rsp_data), 32'd0);
      end

      for (int i = 0; i < 11; i++) begin
         lb_mode = vt[i].lb;
         tdo_pat = vt[i].pat;
         exp_n   = vt[i].n;
         exp_tms = vt[i].tms;
         exp_tdi = vt[i].tdi;
         exp_rsp = vt[i].rsp;
         start_cmd(vt[i].op, vt[i].len, vt[i].data, $sformatf("vec%0d", i));
         wait_rsp($sformatf("vec%0d", i));
         ack_rsp($sformatf("vec%0d", i), i % 2);
      end

      // Stalled response followed by a command waiting during the handshake.
      begin
         int r0;
         lb_mode = 1'b0;
         tdo_pat = 16'h000A;
         model(2'd2, 4'd3, 16'h0003, 1'b0, tdo_pat, exp_n, exp_tms, exp_tdi, exp_rsp);
         start_cmd(2'd2, 4'd3, 16'h0003, "hold");
         wait_rsp("hold");
         r0 = rises;
         for (int k = 0; k < 20; k++) begin
            @(negedge io_clk);
            check($sformatf("hold cyc%0d", k), {13'd0, io_rsp_valid, io_cmd_ready, io_jtag_tck, io_rsp_data},
                  {13'd0, 3'b100, exp_rsp});
         end
         check("hold no tck", 32'(rises), 32'(r0));
         io_cmd_op    = 2'd0;
         io_cmd_len   = 4'd4;
         io_cmd_data  = 16'h0006;
         io_cmd_valid = 1'b1;
         io_rsp_ready = 1'b1;
         tdo_pat      = 16'h0015;
         check("no accept during rsp", 32'(io_cmd_ready), 32'd0);
         @(negedge io_clk);
         io_rsp_ready = 1'b0;
         check("ready after handshake", {30'd0, io_cmd_ready, io_rsp_valid}, {30'd0, 2'b10});
         t_acc = cyc;
         model(2'd0, 4'd4, 16'h0006, 1'b0, tdo_pat, exp_n, exp_tms, exp_tdi, exp_rsp);
         @(negedge io_clk);
         io_cmd_valid = 1'b0;
         check("b2b accepted", 32'(io_busy), 32'd1);
         wait_rsp("b2b");
         ack_rsp("b2b", 0);
      end

      // Reset while bit 3 of a 16-bit shift is in flight.
      begin
         bit reached;
         bit rsp_seen;
         reached  = 1'b0;
         rsp_seen = 1'b0;
         lb_mode  = 1'b1;
         model(2'd1, 4'd15, 16'hFFFF, 1'b1, 16'h0000, exp_n, exp_tms, exp_tdi, exp_rsp);
         start_cmd(2'd1, 4'd15, 16'hFFFF, "midrst");
         for (int k = 0; k < 100; k++) begin
            if (rises >= 4) begin
               reached = 1'b1;
               break;
            end
            @(negedge io_clk);
         end
         check("midrst reach bit3", 32'(reached), 32'd1);
         io_reset = 1'b1;
         @(negedge io_clk);
         check("midrst outputs", {27'd0, io_jtag_tck, io_jtag_tms, io_jtag_tdi, io_rsp_valid, io_busy},
               {27'd0, 5'b01000});
         check("midrst rsp data", 32'(io_rsp_data), 32'd0);
         io_reset = 1'b0;
         for (int k = 0; k < 10; k++) begin
            @(negedge io_clk);
            if (io_rsp_valid) rsp_seen = 1'b1;
         end
         check("midrst no rsp", 32'(rsp_seen), 32'd0);
         check("midrst ready", 32'(io_cmd_ready), 32'd1);
         lb_mode = 1'b0;
         tdo_pat = 16'h0009;
         model(2'd0, 4'd4, 16'h0006, 1'b0, tdo_pat, exp_n, exp_tms, exp_tdi, exp_rsp);
         start_cmd(2'd0, 4'd4, 16'h0006, "post rst");
         wait_rsp("post rst");
         ack_rsp("post rst", 1);
      end

      for (int i = 0; i < 30; i++) begin
         logic [1:0]  rop;
         logic [3:0]  rlen;
         logic [15:0] rdata;
         rop     = 2'($urandom_range(0, 3));
         rlen    = 4'($urandom_range(0, 15));
         rdata   = 16'($urandom);
         lb_mode = 1'($urandom_range(0, 1));
         tdo_pat = 16'($urandom);
         model(rop, rlen, rdata, lb_mode, tdo_pat, exp_n, exp_tms, exp_tdi, exp_rsp);
         start_cmd(rop, rlen, rdata, $sformatf("rnd%0d", i));
         wait_rsp($sformatf("rnd%0d", i));
         ack_rsp($sformatf("rnd%0d", i), int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/jtag_cmd_sequencer.md
# jtag_cmd_sequencer

Command-driven JTAG master that turns a valid/ready command stream into TCK/TMS/TDI bit sequences and returns captured TDO. Sits between an on-chip or testbench command source and the Tote SoC JTAG pins (io_jtag_tck/tms/tdi/tdo). It replaces free-running bit-bang stimulus with a deterministic, clock-divided shift engine usable in simulation and on FPGA.

## Interface
- TICK_DELAY, 10, TCK half-period in io_clk cycles; legal 1..255 (≥3 with JTAG_SEQ_TDO_SYNC_EN)
- MAX_BITS, 16, maximum bits per command; width of data/response
- io_clk  in  1  system clock
- io_reset  in  1  asynchronous, active-high reset
- io_cmd_valid  in  1  command present
- io_cmd_ready  out  1  sequencer accepts command
- io_cmd_op  in  2  0 TMS_SEQ, 1 SHIFT, 2 SHIFT_EXIT, 3 TAP_RESET
- io_cmd_len  in  4  bit count minus one (1..16 bits); ignored for TAP_RESET
- io_cmd_data  in  MAX_BITS  TMS bits (TMS_SEQ) or TDI bits (SHIFT*), LSB first
- io_rsp_valid  out  1  response present
- io_rsp_ready  in  1  consumer accepts response
- io_rsp_data  out  MAX_BITS  captured TDO, bit i = TDO of bit i, unused upper bits 0
- io_jtag_tck  out  1  JTAG clock
- io_jtag_tms  out  1  JTAG mode select
- io_jtag_tdi  out  1  JTAG data to target
- io_jtag_tdo  in  1  JTAG data from target
- io_busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, LOW, HIGH, RSP.
- IDLE: io_cmd_ready=1; on valid&ready latch op, len, data; bit index=0; → LOW.
- LOW (TICK_DELAY cycles): TCK=0; TMS/TDI driven for current bit on entry; → HIGH.
- HIGH (TICK_DELAY cycles): TCK=1; TDO captured into rsp bit[index]; at end, if index==last → RSP (TCK falls), else index+1 → LOW.
- Per-op bit values: TMS_SEQ: TMS=data[i], TDI=0. SHIFT: TMS=0, TDI=data[i]. SHIFT_EXIT: as SHIFT but TMS=1 on last bit. TAP_RESET: 5 bits, TMS=1, TDI=0; response data 0.
- RSP: io_rsp_valid=1, data stable until io_rsp_ready; on handshake → IDLE. Exactly one response per command, in order.
- io_cmd_ready=0 in LOW/HIGH/RSP; a command is never accepted in the cycle a response is consumed.
- Pins hold last driven TMS/TDI while idle; TCK always 0 outside HIGH.
- Reset (any state): state IDLE, index 0, in-flight command and response discarded.
- Reset values: io_cmd_ready=1 (after reset deasserts), io_rsp_valid=0, io_rsp_data=0, io_jtag_tck=0, io_jtag_tms=1, io_jtag_tdi=0, io_busy=0.

## Timing
- Accept at cycle T; first LOW cycle T+1; TCK rises T+1+D, falls T+1+2D (D=TICK_DELAY).
- N-bit command: io_rsp_valid asserts at T+1+2·N·D; TAP_RESET uses N=5.
- TDO captured on the io_clk edge at which io_jtag_tck is registered high (first HIGH cycle).
- Back-to-back: next command accepted earliest one cycle after rsp handshake.
- len=15 → 16 bits; index counter 4 bits, no wrap beyond last.

## Configuration
- JTAG_SEQ_TDO_SYNC_EN defined: io_jtag_tdo passes through two-flop synchronizer; capture occurs 2 io_clk cycles after TCK rise (inside HIGH); TICK_DELAY must be ≥3; latency unchanged.
- Undefined: TDO sampled directly as in Timing; no synchronizer flops.

## Structure
- Package jtag_seq_pkg: op enum (TMS_SEQ, SHIFT, SHIFT_EXIT, TAP_RESET), state enum, TAP_RESET_LEN=5, MAX_BITS default.
- Sub-module jtag_tck_divider: phase counter ($clog2(TICK_DELAY+1) bits), reloads on phase start, emits phase_done pulse.

## Test plan
- After reset: tck=0, tms=1, tdi=0, rsp_valid=0, cmd_ready=1 → all hold with no command.
- TAP_RESET, D=2 → 5 TCK pulses with TMS=1, rsp_valid at T+21, rsp_data=0.
- SHIFT len=7, data=0xA5, target loops TDI→TDO (delayed half-cycle) → TDI sequence 1,0,1,0,0,1,0,1, TMS=0 throughout, rsp_data=0x00A5.
- SHIFT_EXIT len=3, data=0x3 → TMS=0,0,0,1 on bits 0..3; rsp after 8·D+1 cycles.
- Hold io_rsp_ready=0 for 20 cycles → rsp_valid and data stable, cmd_ready=0, no TCK edges; new command accepted 1 cycle after handshake.
- Assert io_reset mid-SHIFT (bit 3 of 16) → next cycle outputs at reset values, no response emitted; following TMS_SEQ len=4 data=0x6 completes normally.
